// File: rtl/mem_ctrl_param.sv
// Parametrised single-port synchronous RAM behind a four-phase en/ready handshake.
// Each accepted command takes WAIT_STATES extra cycles, and an illegal command raises error until en drops.
//   state  | meaning
//   IDLE   | waiting for en; a legal command is latched on accept
//   ACCESS | wait counter runs down; the array access happens at zero
//   DONE   | ready held until the requester drops en
//   FAULT  | error held until the requester drops en
module mem_ctrl_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  fire;
    logic                  mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        error_d = error_q;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    if (read ^ write) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LOAD;
                        wr_d    = write;
                        addr_d  = address;
                        data_d  = input_data;
                    end else begin
                        state_d = FAULT;
                        error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // en is deliberately not looked at here: an accepted access always completes
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    fire    = 1'b1;
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            FAULT: begin
                if (!en) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                error_d = 1'b0;
            end
        endcase

        mem_we = fire & wr_q;
        if (fire && !wr_q) begin
            rdata_d = mem[addr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Array contents survive reset; a reset mid-access leaves state in IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign output_data = rdata_q;
    assign ready       = ready_q;
    assign error       = error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/mem_ctrl_param.md
Name: mem_ctrl_param

Overview:
- Parametrised successor to the team's 8-bit single-port memory block.
- Synchronous RAM behind a four-phase en/ready handshake, with configurable data width, address width and access wait states.
- Adds an error flag for illegal commands and a busy indicator.
- Sits between the CPU control unit and program/data storage; the CPU raises en with read or write, then waits for ready.

Parameters:
DATA_WIDTH, 8, width of input_data/output_data and of each memory word
ADDR_WIDTH, 7, address width; depth = 2**ADDR_WIDTH words
WAIT_STATES, 2, extra cycles between command accept and completion (0 legal)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  request strobe; held high by requester until ready or error seen
read  input  1  read command, sampled with en in IDLE
write  input  1  write command, sampled with en in IDLE
address  input  ADDR_WIDTH  word address, sampled at accept
input_data  input  DATA_WIDTH  write data, sampled at accept
output_data  output  DATA_WIDTH  read data, registered
ready  output  1  access complete; held until en low
busy  output  1  high in every state except IDLE
error  output  1  illegal command; held until en low

Behaviour:
- Reset (async, any state, mid-access included):
  - state=IDLE.
  - output_data=0, ready=0, error=0, busy=0, wait counter=0.
  - Memory array is not cleared; an aborted write does not update the array.
- State machine: IDLE, ACCESS, DONE, FAULT.
- IDLE:
  - On an edge with en=1 and exactly one of read/write high: latch command, address, input_data, then go to ACCESS. The counter loads WAIT_STATES.
  - On an edge with en=1 and read=write (both 0 or both 1): go to FAULT, no array access.
  - en=0: stay in IDLE.
- ACCESS:
  - Counter>0: decrement and stay.
  - Counter==0: perform the access and go to DONE.
    - Write: mem[addr_latched] <= data_latched.
    - Read: output_data <= mem[addr_latched].
  - read, write, address and input_data changes are ignored after accept.
  - en dropping during ACCESS does not abort; the access completes.
- DONE:
  - ready=1 (registered, set on the edge entering DONE).
  - en=0 at an edge: go to IDLE, ready=0.
  - en still 1: stay; no new accept until en has been seen low.
- FAULT:
  - error=1 (registered); stay while en=1; en=0 at an edge goes to IDLE, error=0.
- Latency: accept at edge k → ready high after edge k+WAIT_STATES+1.
  - WAIT_STATES=2: accept edge k, ACCESS at k+1..k+2, access+ready at k+3.
  - WAIT_STATES=0: ready after edge k+1.
- Minimum handshake turnaround is one IDLE cycle. en high in IDLE immediately after DONE (en dropped for exactly one edge) is a new request.
- output_data holds its last read value through writes, errors and IDLE; only a completed read or reset changes it.
- ready and error are never high together; busy=0 in IDLE only.
- Address width rule: address is used unextended, so there is no out-of-range case and all 2**ADDR_WIDTH locations are valid. Wrap-around is not applicable.

Test Plan:
1. Reset, then write: write=1, read=0, address=1, input_data=8'hFF, en=1 held. → busy=1 after the accept edge; ready=1 exactly 3 edges after accept; output_data stays 0. Drop en → ready=0 and busy=0 at the next edge.
2. Read back: read=1, address=1, en=1. → ready after 3 edges with output_data=8'hFF. Hold en 4 extra cycles → ready stays 1, no second access.
3. Illegal commands: en=1 with read=1, write=1 → error=1 next edge, ready=0, mem[1] still 8'hFF. Repeat with read=0, write=0 → same result. Drop en → error clears.
4. Mid-access changes and reset:
   - Write address=5, data=8'hA5; change address to 6 and input_data to 8'h00 during ACCESS → read of 5 gives 8'hA5, read of 6 is unaffected.
   - Start a write of 8'h3C to address 7, assert reset during ACCESS → all outputs 0 immediately, state IDLE; read of 7 ≠ 8'h3C (pre-write it with 8'h11 and expect 8'h11).
5. Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=4, WAIT_STATES=0.
   - Write 16'hBEEF to address 15 → ready one edge after accept.
   - Read address 15 → 16'hBEEF.
   - Back-to-back requests with en low for one edge → both complete, two ready pulses.
6. en dropped during ACCESS (WAIT_STATES=2, write 8'h42 to address 3) → ready pulses high for one cycle in DONE, then IDLE. Read of address 3 returns 8'h42.
